// File: rtl/bp_dma_mem_responder_pkg.sv
// Shared types and helpers for the per-bank DMA memory responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bp_dma_mem_responder_pkg;

    // Responder service states; only one packet is ever in service.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LAT  = 2'd1,
        SEND = 2'd2,
        RECV = 2'd3
    } bp_dma_resp_state_e;

    // Default DMA address width of the bank interface.
    localparam int unsigned dma_daddr_width_lp = 28;

    // Packet layout at the default address width: {write_not_read, addr}.
    typedef struct packed {
        logic                          write_not_read;
        logic [dma_daddr_width_lp-1:0] addr;
    } bp_dma_pkt_s;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/bp_dma_mem_responder_mem_1r1w.sv
// Word array with one synchronous write port and one combinational read port.
// Latency: write lands at the clock edge; read data is same-cycle.
// Backpressure: none; the owner gates both ports with its own handshakes.
module bp_dma_mem_responder_mem_1r1w #(
    parameter int els_p   = 1024,
    parameter int width_p = 64
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    // Contents are deliberately left unreset: this is bulk storage.
    logic [width_p-1:0] mem_q [els_p];

    // Write port: one word per accepted writeback beat.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    // Read port is combinational so a stalled beat simply keeps re-reading the same word.
    assign r_data_o = r_v_i ? mem_q[r_addr_i] : '0;

endmodule

// File: rtl/bp_dma_mem_responder.sv
// Memory-side endpoint of one L2 bank's DMA port: fills reads, absorbs writebacks.
// Latency: first fill beat read_latency_p+1 cycles after the read accept, then one beat per handshake.
// Backpressure: packet ready only in IDLE; fill beats held stable until dma_data_ready_and_i.
module bp_dma_mem_responder
    import bp_dma_mem_responder_pkg::*;
#(
    parameter int daddr_width_p  = 28,
    parameter int data_width_p   = 64,
    parameter int block_width_p  = 512,
    parameter int mem_els_p      = 1024,
    parameter int read_latency_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [daddr_width_p:0]   dma_pkt_i,
    input  logic                     dma_pkt_v_i,
    output logic                     dma_pkt_ready_and_o,
    output logic [data_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_ready_and_i,
    input  logic [data_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_ready_and_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int beats_lp    = block_width_p / data_width_p;
    localparam int beat_w_lp   = $clog2(beats_lp);
    localparam int byte_off_lp = $clog2(data_width_p / 8);
    localparam int word_w_lp   = $clog2(mem_els_p);
    // Block index = word index with the beat bits stripped off.
    localparam int blk_w_lp    = word_w_lp - beat_w_lp;
    localparam int lat_w_lp    = clog2_min1(read_latency_p + 1);
    localparam logic [daddr_width_p:0] cap_lp =
        (daddr_width_p + 1)'(mem_els_p * (data_width_p / 8));
    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(beats_lp - 1);
    localparam logic [lat_w_lp-1:0]  lat_load_lp  = lat_w_lp'(read_latency_p - 1);

    bp_dma_resp_state_e     state_q, state_d;
    logic [beat_w_lp-1:0]   beat_q, beat_d;
    logic [lat_w_lp-1:0]    lat_q, lat_d;
    logic [blk_w_lp-1:0]    blk_q, blk_d;
    logic                   in_range_q, in_range_d;
    logic                   err_q, err_d;

    logic                     pkt_wnr;
    logic [daddr_width_p-1:0] pkt_addr;
    logic [blk_w_lp-1:0]      pkt_blk;
    logic                     pkt_in_range;
    logic                     last_beat;
    logic [word_w_lp-1:0]     word_addr;
    logic                     mem_w_v;
    logic                     mem_r_v;
    logic [data_width_p-1:0]  mem_r_data;

    assign pkt_wnr  = dma_pkt_i[daddr_width_p];
    assign pkt_addr = dma_pkt_i[daddr_width_p-1:0];
    // Dropping the byte-in-word and beat bits block-aligns the address.
    assign pkt_blk      = pkt_addr[byte_off_lp + beat_w_lp +: blk_w_lp];
    assign pkt_in_range = ({1'b0, pkt_addr} < cap_lp);
    assign last_beat    = (beat_q == last_beat_lp);
    // Beat sits in the low bits, so a burst can never carry into the next block.
    assign word_addr    = {blk_q, beat_q};

    // Next-state and counter logic for the single-outstanding-packet FSM.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        blk_d      = blk_q;
        in_range_d = in_range_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (dma_pkt_v_i) begin
                    blk_d      = pkt_blk;
                    in_range_d = pkt_in_range;
                    err_d      = err_q | ~pkt_in_range;
                    beat_d     = '0;
                    if (pkt_wnr) begin
                        state_d = RECV;
                    end else begin
                        state_d = LAT;
                        lat_d   = lat_load_lp;
                    end
                end
            end
            LAT: begin
                if (lat_q == '0) begin
                    state_d = SEND;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            SEND: begin
                if (dma_data_ready_and_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RECV: begin
                if (dma_data_v_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State, counters and sticky error; reset abandons any burst in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            lat_q      <= '0;
            blk_q      <= '0;
            in_range_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            blk_q      <= blk_d;
            in_range_q <= in_range_d;
            err_q      <= err_d;
        end
    end

    // Out-of-range packets still run the full handshake but never touch the array.
    assign mem_w_v = (state_q == RECV) & dma_data_v_i & in_range_q;
    assign mem_r_v = (state_q == SEND) & in_range_q;

    bp_dma_mem_responder_mem_1r1w #(
        .els_p   (mem_els_p),
        .width_p (data_width_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_w_v),
        .w_addr_i (word_addr),
        .w_data_i (dma_data_i),
        .r_v_i    (mem_r_v),
        .r_addr_i (word_addr),
        .r_data_o (mem_r_data)
    );

    assign dma_pkt_ready_and_o  = (state_q == IDLE);
    assign dma_data_v_o         = (state_q == SEND);
    assign dma_data_ready_and_o = (state_q == RECV);
    assign dma_data_o           = mem_r_data;
    assign busy_o               = (state_q != IDLE);
    assign err_o                = err_q;

endmodule
